// File: rtl/matvec_result_writer.sv
`default_nettype none
// ============================================================================
// Module      : matvec_result_writer
// Description : Snapshots the engine result vector on a rising results_valid
//               and writes it to memory through an Avalon-MM write master.
// Revision    : 1.0 - initial release
// ============================================================================
module matvec_result_writer #(
    parameter int          NUM_RESULTS  = 8,
    parameter int          RESULT_WIDTH = 24,
    parameter int          ADDR_WIDTH   = 32,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0010,
    parameter int          ADDR_STRIDE  = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                results_valid,
    input  logic [NUM_RESULTS*RESULT_WIDTH-1:0] c_in,
    output logic [ADDR_WIDTH-1:0]               mm_address,
    output logic                                mm_write,
    output logic [31:0]                         mm_writedata,
    output logic [3:0]                          mm_byteenable,
    input  logic                                mm_waitrequest,
    output logic                                busy,
    output logic                                wb_done,
    output logic [RESULT_WIDTH+2:0]             checksum
);

    localparam int IDX_W  = (NUM_RESULTS > 1) ? $clog2(NUM_RESULTS) : 1;
    localparam int CSUM_W = RESULT_WIDTH + 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] C_BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] C_STRIDE   = ADDR_WIDTH'(ADDR_STRIDE);
    localparam logic [IDX_W-1:0]      C_LAST_IDX = IDX_W'(NUM_RESULTS - 1);

    logic [1:0]                                  state_q, state_d;
    logic [IDX_W-1:0]                            idx_q, idx_d;
    logic [NUM_RESULTS-1:0][RESULT_WIDTH-1:0]    snap_q, snap_d;
    logic                                        rv_q, rv_d;
    logic [CSUM_W-1:0]                           checksum_q, checksum_d;
    logic                                        mm_write_q, mm_write_d;
    logic [ADDR_WIDTH-1:0]                       mm_address_q, mm_address_d;
    logic [31:0]                                 mm_writedata_q, mm_writedata_d;
    logic [3:0]                                  mm_byteenable_q, mm_byteenable_d;
    logic                                        busy_q, busy_d;
    logic                                        wb_done_q, wb_done_d;
    logic [IDX_W-1:0]                            idx_nxt;

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        snap_d          = snap_q;
        rv_d            = results_valid;
        checksum_d      = checksum_q;
        mm_write_d      = mm_write_q;
        mm_address_d    = mm_address_q;
        mm_writedata_d  = mm_writedata_q;
        mm_byteenable_d = mm_byteenable_q;
        busy_d          = busy_q;
        wb_done_d       = wb_done_q;
        idx_nxt         = idx_q + IDX_W'(1);

        case (state_q)
            S_IDLE: begin
                // Only a rising edge seen here starts a transfer; edges elsewhere are dropped.
                if (results_valid && !rv_q) begin
                    state_d         = S_WRITE;
                    snap_d          = c_in;
                    idx_d           = '0;
                    checksum_d      = '0;
                    mm_write_d      = 1'b1;
                    mm_address_d    = C_BASE;
                    // Snapshot is not loaded yet, so the first word comes straight from c_in.
                    mm_writedata_d  = 32'(c_in[RESULT_WIDTH-1:0]);
                    mm_byteenable_d = 4'hF;
                    busy_d          = 1'b1;
                    wb_done_d       = 1'b0;
                end
            end
            S_WRITE: begin
                if (!mm_waitrequest) begin
                    checksum_d = checksum_q + CSUM_W'(snap_q[idx_q]);
                    if (idx_q == C_LAST_IDX) begin
                        state_d         = S_DONE;
                        mm_write_d      = 1'b0;
                        mm_address_d    = '0;
                        mm_writedata_d  = '0;
                        mm_byteenable_d = 4'h0;
                        busy_d          = 1'b0;
                        wb_done_d       = 1'b1;
                    end else begin
                        idx_d          = idx_nxt;
                        mm_address_d   = C_BASE + ADDR_WIDTH'(idx_nxt) * C_STRIDE;
                        mm_writedata_d = 32'(snap_q[idx_nxt]);
                    end
                end
            end
            S_DONE: begin
                if (!results_valid) begin
                    state_d   = S_IDLE;
                    wb_done_d = 1'b0;
                end
            end
            default: begin
                state_d         = S_IDLE;
                idx_d           = '0;
                mm_write_d      = 1'b0;
                mm_address_d    = '0;
                mm_writedata_d  = '0;
                mm_byteenable_d = 4'h0;
                busy_d          = 1'b0;
                wb_done_d       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            idx_q           <= '0;
            snap_q          <= '0;
            rv_q            <= 1'b0;
            checksum_q      <= '0;
            mm_write_q      <= 1'b0;
            mm_address_q    <= '0;
            mm_writedata_q  <= '0;
            mm_byteenable_q <= 4'h0;
            busy_q          <= 1'b0;
            wb_done_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            snap_q          <= snap_d;
            rv_q            <= rv_d;
            checksum_q      <= checksum_d;
            mm_write_q      <= mm_write_d;
            mm_address_q    <= mm_address_d;
            mm_writedata_q  <= mm_writedata_d;
            mm_byteenable_q <= mm_byteenable_d;
            busy_q          <= busy_d;
            wb_done_q       <= wb_done_d;
        end
    end

    assign mm_address    = mm_address_q;
    assign mm_write      = mm_write_q;
    assign mm_writedata  = mm_writedata_q;
    assign mm_byteenable = mm_byteenable_q;
    assign busy          = busy_q;
    assign wb_done       = wb_done_q;
    assign checksum      = checksum_q;

endmodule
`default_nettype wire
